// File: rtl/decode_execute_stage.sv
// Decode-to-execute pipeline register with valid/ready handshake, 2-entry skid
// buffer, synchronous flush, optional bubble zeroing and a saturating stall counter.
module decode_execute_stage #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned REGIDX_W    = 4,
  parameter int unsigned CTRL_W      = 11,
  parameter int unsigned ZERO_BUBBLE = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CTRL_W-1:0]   ctrl_in,
  input  logic [REGIDX_W-1:0] reg_dest_in,
  input  logic [DATA_W-1:0]   srcA_in,
  input  logic [DATA_W-1:0]   srcB_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CTRL_W-1:0]   ctrl_out,
  output logic [REGIDX_W-1:0] reg_dest_out,
  output logic [DATA_W-1:0]   srcA_out,
  output logic [DATA_W-1:0]   srcB_out,
  output logic [CNT_W-1:0]    stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_out_valid;
  logic                r_in_ready;
  logic [CTRL_W-1:0]   r_m_ctrl, r_s_ctrl;
  logic [REGIDX_W-1:0] r_m_dest, r_s_dest;
  logic [DATA_W-1:0]   r_m_a, r_s_a;
  logic [DATA_W-1:0]   r_m_b, r_s_b;
  logic [CNT_W-1:0]    r_stall;

  logic w_accept;
  logic w_drain;
  logic w_load_m_in;
  logic w_load_m_s;
  logic w_load_s;

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = r_out_valid & out_ready;

  always_comb begin
    w_state_next = r_state;
    w_load_m_in  = 1'b0;
    w_load_m_s   = 1'b0;
    w_load_s     = 1'b0;
    if (flush) begin
      w_state_next = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_next = ONE;
            w_load_m_in  = 1'b1;
          end
        end
        ONE: begin
          if (w_accept && w_drain) begin
            w_load_m_in = 1'b1;
          end else if (w_accept) begin
            w_state_next = TWO;
            w_load_s     = 1'b1;
          end else if (w_drain) begin
            w_state_next = EMPTY;
          end
        end
        TWO: begin
          if (w_drain) begin
            w_state_next = ONE;
            w_load_m_s   = 1'b1;
          end
        end
        default: w_state_next = EMPTY;
      endcase
    end
  end

  // Handshake flags are flopped from the next-state decode so in_ready never
  // sees out_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= (w_state_next != EMPTY);
      r_in_ready  <= (w_state_next != TWO);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_ctrl <= '0;
      r_m_dest <= '0;
      r_m_a    <= '0;
      r_m_b    <= '0;
      r_s_ctrl <= '0;
      r_s_dest <= '0;
      r_s_a    <= '0;
      r_s_b    <= '0;
    end else begin
      if (w_load_m_in) begin
        r_m_ctrl <= ctrl_in;
        r_m_dest <= reg_dest_in;
        r_m_a    <= srcA_in;
        r_m_b    <= srcB_in;
      end else if (w_load_m_s) begin
        r_m_ctrl <= r_s_ctrl;
        r_m_dest <= r_s_dest;
        r_m_a    <= r_s_a;
        r_m_b    <= r_s_b;
      end
      if (w_load_s) begin
        r_s_ctrl <= ctrl_in;
        r_s_dest <= reg_dest_in;
        r_s_a    <= srcA_in;
        r_s_b    <= srcB_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
    end else if (r_out_valid && !out_ready && (r_stall != '1)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign ctrl_out     = ((ZERO_BUBBLE != 0) && !r_out_valid) ? '0 : r_m_ctrl;
  assign reg_dest_out = r_m_dest;
  assign srcA_out     = r_m_a;
  assign srcB_out     = r_m_b;
  assign stall_cnt    = r_stall;

endmodule

// File: tb/tb_decode_execute_stage.sv
// Directed bench for decode_execute_stage: a queue of expected instructions is
// compared against the execute side; a second instance covers CNT_W=4 / ZERO_BUBBLE=0.
module tb_decode_execute_stage;

  typedef struct {
    logic [10:0] c;
    logic [3:0]  d;
    logic [15:0] a;
    logic [15:0] b;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [10:0] ctrl_in;
  logic [3:0]  reg_dest_in;
  logic [15:0] srcA_in;
  logic [15:0] srcB_in;

  logic        o1_in_ready, o1_out_valid;
  logic [10:0] o1_ctrl;
  logic [3:0]  o1_dest;
  logic [15:0] o1_a, o1_b;
  logic [15:0] o1_stall;

  logic        o2_in_ready, o2_out_valid;
  logic [10:0] o2_ctrl;
  logic [3:0]  o2_dest;
  logic [15:0] o2_a, o2_b;
  logic [3:0]  o2_stall;

  int unsigned checks = 0;
  int unsigned errors = 0;

  item_t       q[$];
  item_t       last;
  logic        last_known;
  logic [15:0] m_stall16;
  logic [3:0]  m_stall4;

  always #5 clk = ~clk;

  decode_execute_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(o1_in_ready),
    .ctrl_in(ctrl_in), .reg_dest_in(reg_dest_in), .srcA_in(srcA_in), .srcB_in(srcB_in),
    .out_valid(o1_out_valid), .out_ready(out_ready),
    .ctrl_out(o1_ctrl), .reg_dest_out(o1_dest), .srcA_out(o1_a), .srcB_out(o1_b),
    .stall_cnt(o1_stall)
  );

  decode_execute_stage #(.CNT_W(4), .ZERO_BUBBLE(0)) dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(o2_in_ready),
    .ctrl_in(ctrl_in), .reg_dest_in(reg_dest_in), .srcA_in(srcA_in), .srcB_in(srcB_in),
    .out_valid(o2_out_valid), .out_ready(out_ready),
    .ctrl_out(o2_ctrl), .reg_dest_out(o2_dest), .srcA_out(o2_a), .srcB_out(o2_b),
    .stall_cnt(o2_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic item_t mk(input logic [15:0] a);
    item_t it;
    it.c = {a[6:0], a[3:0]};
    it.d = a[3:0] ^ 4'hA;
    it.a = a;
    it.b = ~a;
    return it;
  endfunction

  task automatic model_reset();
    q.delete();
    last       = mk(16'h0);
    last.c     = '0;
    last.d     = '0;
    last.b     = '0;
    last_known = 1'b1;
    m_stall16  = '0;
    m_stall4   = '0;
  endtask

  // One clock: drive at posedge+1, check mid-cycle, advance the model at the edge.
  task automatic cycle(input logic v, input logic rdy, input logic fl, input logic [15:0] a);
    item_t it;
    logic  acc, drn;
    it          = mk(a);
    in_valid    = v;
    out_ready   = rdy;
    flush       = fl;
    ctrl_in     = it.c;
    reg_dest_in = it.d;
    srcA_in     = it.a;
    srcB_in     = it.b;
    #4;
    chk("out_valid",  32'(o1_out_valid), 32'(q.size() > 0));
    chk("in_ready",   32'(o1_in_ready),  32'(q.size() < 2));
    chk("out_valid2", 32'(o2_out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("srcA_out",     32'(o1_a),    32'(q[0].a));
      chk("srcB_out",     32'(o1_b),    32'(q[0].b));
      chk("reg_dest_out", 32'(o1_dest), 32'(q[0].d));
      chk("ctrl_out",     32'(o1_ctrl), 32'(q[0].c));
      chk("ctrl_out2",    32'(o2_ctrl), 32'(q[0].c));
    end else begin
      chk("bubble_ctrl_zero", 32'(o1_ctrl), 32'h0);
      if (last_known) chk("zb0_ctrl_hold", 32'(o2_ctrl), 32'(last.c));
    end
    chk("stall_cnt",  32'(o1_stall), 32'(m_stall16));
    chk("stall_cnt4", 32'(o2_stall), 32'(m_stall4));

    acc = v && (q.size() < 2);
    drn = (q.size() > 0) && rdy;
    if ((q.size() > 0) && !rdy) begin
      if (m_stall16 != 16'hFFFF) m_stall16++;
      if (m_stall4 != 4'hF) m_stall4++;
    end
    if (fl) begin
      if (q.size() > 0) last = q[0];
      last_known = 1'b0;
      q.delete();
    end else begin
      if (drn) begin
        last       = q.pop_front();
        last_known = 1'b1;
      end
      if (acc) q.push_back(it);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ctrl_in = '0; reg_dest_in = '0; srcA_in = '0; srcB_in = '0;
    model_reset();
    #2;
    chk("rst_out_valid", 32'(o1_out_valid), 32'h0);
    chk("rst_in_ready",  32'(o1_in_ready),  32'h1);
    chk("rst_stall",     32'(o1_stall),     32'h0);
    chk("rst_srcA",      32'(o1_a),         32'h0);
    chk("rst_ctrl2",     32'(o2_ctrl),      32'h0);
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Streaming at full rate
    for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b1, 1'b0, 16'(i));
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);

    // Back-pressure into TWO; input offered while full must be ignored
    cycle(1'b1, 1'b0, 1'b0, 16'h1111);
    cycle(1'b1, 1'b0, 1'b0, 16'h2222);
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'hBEEF);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);

    // Flush while full, with a valid input in the same cycle
    cycle(1'b1, 1'b0, 1'b0, 16'h4444);
    cycle(1'b1, 1'b0, 1'b0, 16'h5555);
    cycle(1'b1, 1'b0, 1'b1, 16'h3333);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);

    // Flush in ONE while execute drains in the same cycle
    cycle(1'b1, 1'b1, 1'b0, 16'h6666);
    cycle(1'b1, 1'b1, 1'b1, 16'h6767);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);

    // Stall counter saturation on the 4-bit instance
    cycle(1'b1, 1'b0, 1'b0, 16'h0ABC);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0);
    chk("sat_stall4", 32'(o2_stall), 32'hF);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    chk("zb0_last_ctrl", 32'(o2_ctrl), 32'(mk(16'h0ABC).c));

    // Asynchronous reset mid-cycle while holding one entry
    cycle(1'b1, 1'b0, 1'b0, 16'h7777);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #3;
    chk("pre_rst_valid", 32'(o1_out_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(o1_out_valid), 32'h0);
    chk("arst_stall",     32'(o1_stall),     32'h0);
    chk("arst_srcA",      32'(o1_a),         32'h0);
    chk("arst_srcB",      32'(o1_b),         32'h0);
    chk("arst_dest",      32'(o1_dest),      32'h0);
    chk("arst_ctrl2",     32'(o2_ctrl),      32'h0);
    chk("arst_in_ready",  32'(o1_in_ready),  32'h1);
    #2;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b1, 1'b0, 16'h8888);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_execute_stage.md
Name: decode_execute_stage

Overview:
- Parametrised successor to the fixed decode/execute pipeline register.
- Carries a generic control bundle, destination register index and two operands between decode and execute.
- Adds a valid/ready handshake with a 2-entry skid buffer, so execute back-pressure never drops or duplicates an instruction.
- Adds synchronous flush for branch squash, optional bubble zeroing, and a saturating stall counter for performance debug.

Parameters:
- DATA_W, 16, width of each operand (srcA, srcB).
- REGIDX_W, 4, width of the destination register index.
- CTRL_W, 11, width of the packed control bundle: wbs, mm, ALUop[2:0], wm, am, ni, wme, alu_mux, alu_mux1.
- ZERO_BUBBLE, 1, when 1, ctrl_out is forced to all-zero whenever out_valid=0.
- CNT_W, 16, width of stall_cnt.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  squash all held entries and the same-cycle input.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept; a registered signal.
- ctrl_in  in  CTRL_W  control bundle.
- reg_dest_in  in  REGIDX_W  destination register index.
- srcA_in  in  DATA_W  operand A.
- srcB_in  in  DATA_W  operand B.
- out_valid  out  1  execute-side entry valid.
- out_ready  in  1  execute consumes this cycle.
- ctrl_out  out  CTRL_W  control bundle.
- reg_dest_out  out  REGIDX_W  destination register index.
- srcA_out  out  DATA_W  operand A.
- srcB_out  out  DATA_W  operand B.
- stall_cnt  out  CNT_W  count of stalled cycles.

Behaviour:
- Definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Storage: main entry M drives the outputs; skid entry S is used only under back-pressure.
- Reset (asynchronous, immediate): state=EMPTY, out_valid=0, in_ready=1, stall_cnt=0, M and S payloads all zero.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - TWO: out_valid=1, in_ready=0.
- Transitions when flush=0:
  - EMPTY: accept -> ONE, M<=input. Otherwise stay in EMPTY.
  - ONE, accept & drain: stay in ONE, M<=input.
  - ONE, accept & !drain: -> TWO, S<=input, M held.
  - ONE, !accept & drain: -> EMPTY.
  - ONE, neither: stay in ONE, M held.
  - TWO: drain -> ONE, M<=S. Otherwise stay in TWO. Input is never accepted in TWO.
- Latency: an accepted instruction appears on the outputs on the next rising edge (1 cycle) when the stage was EMPTY or draining. Otherwise it appears after the entries ahead of it drain.
- Ordering: strict FIFO; M is always older than S.
- in_ready depends only on registered state, never combinationally on out_ready.
- Flush:
  - Next edge: state=EMPTY, out_valid=0, in_ready=1.
  - The same-cycle input is discarded even if in_valid=1.
  - Flush has priority over accept and drain. The drain handshake in a flush cycle still counts as consumed by execute.
  - Payload registers may keep stale data, but the outputs obey ZERO_BUBBLE.
- ZERO_BUBBLE=1: ctrl_out=0 whenever out_valid=0. reg_dest_out, srcA_out and srcB_out show the stale M contents. ZERO_BUBBLE=0: all outputs show M.
- stall_cnt: increments by 1 each cycle with out_valid & !out_ready. Saturates at 2^CNT_W-1 with no wrap. Unaffected by flush; cleared only by rst.
- Widths: payloads pass through unmodified; no arithmetic.
- Reset mid-operation: all held entries are lost immediately; the counter returns to 0.

Test Plan:
- Streaming: out_ready=1, send srcA=0x0001..0x0005 on consecutive cycles -> each appears 1 cycle later in order, in_ready stays 1, stall_cnt=0.
- Back-pressure: send A=0x1111, then B=0x2222 with out_ready=0 -> state TWO, in_ready=0 on the following cycle, outputs show 0x1111. Raise out_ready -> 0x1111, then 0x2222 on consecutive cycles. stall_cnt equals the number of out_ready=0 cycles with out_valid=1.
- Flush in TWO with in_valid=1, srcA=0x3333 -> next cycle out_valid=0, ctrl_out=0, in_ready=1. 0x3333 never appears.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15.
- Asynchronous reset asserted mid-cycle in state ONE -> out_valid=0, stall_cnt=0, outputs zero before the next clk edge. After release, the first accept behaves as from EMPTY.
- ZERO_BUBBLE=0 after a drain to EMPTY -> ctrl_out retains the last control value while out_valid=0.
